// File: rtl/cla_pipe_adder_if.sv
// cla_pipe_adder_if: operand and result streams of the pipelined CLA adder.
// Optional ovf signal is present only when CLA_PIPE_OVF_EN is defined.
// Handshake: a beat moves when valid and ready are both high at a rising edge;
// ready never depends on valid, and a producer holds its beat steady until taken.
`timescale 1ns/1ps
interface cla_pipe_adder_if #(
    parameter int WIDTH = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             cout;
`ifdef CLA_PIPE_OVF_EN
    logic             ovf;
`endif

    // Adder side: consumes operands, produces results.
    modport slave (
        input  in_valid, A, B, cin, sub, out_ready,
        output in_ready, out_valid, S, cout
`ifdef CLA_PIPE_OVF_EN
        , output ovf
`endif
    );

    // Environment side: produces operands, consumes results.
    modport master (
        output in_valid, A, B, cin, sub, out_ready,
        input  in_ready, out_valid, S, cout
`ifdef CLA_PIPE_OVF_EN
        , input ovf
`endif
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
// WIDTH bits are split into GROUP-bit lookahead slices; slice k is computed in
// stage k, so the carry crosses one register per slice (STAGES = WIDTH/GROUP).
// Optional feature macro: CLA_PIPE_OVF_EN adds a registered signed-overflow flag.
`timescale 1ns/1ps
module cla_pipe_adder #(
    parameter int WIDTH = 24,
    parameter int GROUP = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    cla_pipe_adder_if.slave pipe
);
    localparam int STAGES = (GROUP > 0) ? (WIDTH / GROUP) : 1;
    localparam int LAST   = STAGES - 1;

    // Reject configurations that would leave a partial slice.
    if ((GROUP < 1) || (GROUP > 8) || ((WIDTH % GROUP) != 0) || (WIDTH < GROUP)) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP and GROUP in 1..8");
    end

    // One lookahead slice: every internal carry is a flat sum of products of
    // G/P terms and the slice carry-in, so no carry depends on a lower carry.
    function automatic logic [GROUP:0] cla_slice(
        input logic [GROUP-1:0] a,
        input logic [GROUP-1:0] b,
        input logic             c0
    );
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP:0]   c;
        logic             term;
        p    = a | b;
        g    = a & b;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
            term = c0;
            for (int m = 0; m <= i; m++) begin
                term = term & p[m];
            end
            c[i+1] = c[i+1] | term;
        end
        return {c[GROUP], a ^ b ^ c[GROUP-1:0]};
    endfunction

    // Stage registers: valid, finished low sum bits, slice carry-out, and the
    // operands still needed by the stages above.
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  bp_q  [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];

    // What each stage would load: its upstream beat plus the new slice result.
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_bp  [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [STAGES-1:0] carry_d;
    logic [STAGES-1:0] adv;

`ifdef CLA_PIPE_OVF_EN
    logic ovf_q;
    logic ovf_d;
`endif

    // Upstream beat for every stage: ports for stage 0, previous register otherwise.
    always_comb begin
        src_a[0]   = pipe.A;
        src_bp[0]  = pipe.B ^ {WIDTH{pipe.sub}};
        src_c[0]   = pipe.sub | pipe.cin;
        src_sum[0] = '0;
        valid_d[0] = pipe.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]   = a_q[k-1];
            src_bp[k]  = bp_q[k-1];
            src_c[k]   = carry_q[k-1];
            src_sum[k] = sum_q[k-1];
            valid_d[k] = valid_q[k-1];
        end
    end

    // Each stage resolves its own slice and merges it into the running sum.
    always_comb begin
        logic [GROUP:0] slice_res;
        slice_res = '0;
        for (int k = 0; k < STAGES; k++) begin
            slice_res = cla_slice(src_a[k][k*GROUP +: GROUP],
                                  src_bp[k][k*GROUP +: GROUP],
                                  src_c[k]);
            sum_d[k]                  = src_sum[k];
            sum_d[k][k*GROUP +: GROUP] = slice_res[GROUP-1:0];
            carry_d[k]                = slice_res[GROUP];
        end
    end

    // Stall chain: a stage may load if it or any stage above it is empty, or
    // the consumer takes the output beat this cycle.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_full = all_full & valid_q[k];
            adv[k]   = pipe.out_ready | ~all_full;
        end
    end

`ifdef CLA_PIPE_OVF_EN
    // Signed overflow: operands agree in sign but the result does not.
    always_comb begin
        ovf_d = (src_a[LAST][WIDTH-1] == src_bp[LAST][WIDTH-1]) &
                (sum_d[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
    end
`endif

    // Pipeline registers: advance where allowed, hold otherwise; reset drops all beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                bp_q[k]  <= '0;
                sum_q[k] <= '0;
            end
`ifdef CLA_PIPE_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= valid_d[k];
                    if (valid_d[k]) begin
                        a_q[k]     <= src_a[k];
                        bp_q[k]    <= src_bp[k];
                        sum_q[k]   <= sum_d[k];
                        carry_q[k] <= carry_d[k];
                    end
                end
            end
`ifdef CLA_PIPE_OVF_EN
            if (adv[LAST] && valid_d[LAST]) begin
                ovf_q <= ovf_d;
            end
`endif
        end
    end

    assign pipe.in_ready  = adv[0];
    assign pipe.out_valid = valid_q[LAST];
    assign pipe.S         = sum_q[LAST];
    assign pipe.cout      = carry_q[LAST];
`ifdef CLA_PIPE_OVF_EN
    assign pipe.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed and random beats through cla_pipe_adder with a
// queue-based scoreboard of {ovf, cout, S}. Build with CLA_PIPE_OVF_EN to
// cover the overflow flag.
`timescale 1ns/1ps
module tb_cla_pipe_adder;
    localparam int WIDTH  = 24;
    localparam int GROUP  = 6;
    localparam int STAGES = WIDTH / GROUP;
    localparam int EW     = WIDTH + 2;
`ifdef CLA_PIPE_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;
    logic          obs_ovf;

    cla_pipe_adder_if #(.WIDTH(WIDTH)) pipe();

    cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pipe  (pipe)
    );

`ifdef CLA_PIPE_OVF_EN
    assign obs_ovf = pipe.ovf;
`else
    assign obs_ovf = 1'b0;
`endif

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] exp_word(input logic ov, input logic co, input logic [WIDTH-1:0] s);
        return {ov & OVF_ON, co, s};
    endfunction

    // Reference arithmetic: unsigned add with carry, or subtract with no-borrow flag.
    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic ci, input logic sb);
        logic [WIDTH:0] r;
        logic           b_msb;
        logic           ov;
        if (sb) r = {a >= b, a - b};
        else    r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        b_msb = sb ? ~b[WIDTH-1] : b[WIDTH-1];
        ov    = (a[WIDTH-1] == b_msb) && (r[WIDTH-1] != a[WIDTH-1]);
        return exp_word(ov, r[WIDTH], r[WIDTH-1:0]);
    endfunction

    // Scoreboard: every result transfer is compared against the oldest accepted beat.
    always @(negedge clk) begin
        if (rst_n && pipe.out_valid && pipe.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", 32'(pipe.out_valid), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", 32'({obs_ovf, pipe.cout, pipe.S}), 32'(mon_exp));
            end
        end
    end

    // Driver: present a beat, wait until it is taken, record its expected result.
    // Called and returns at 1 ns after a rising edge.
    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic sb, input logic [EW-1:0] e);
        int waited;
        waited        = 0;
        pipe.A        = a;
        pipe.B        = b;
        pipe.cin      = ci;
        pipe.sub      = sb;
        pipe.in_valid = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!pipe.in_ready && waited < 200);
        if (!pipe.in_ready) begin
            check("push_timeout", 32'(pipe.in_ready), 32'd1);
            pipe.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(e);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        repeat (STAGES + 2) @(posedge clk);
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int edges;
        int t0;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic             rs;

        pipe.in_valid  = 1'b0;
        pipe.A         = '0;
        pipe.B         = '0;
        pipe.cin       = 1'b0;
        pipe.sub       = 1'b0;
        pipe.out_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 32'(pipe.out_valid), 32'd0);
        check("reset_S", 32'(pipe.S), 32'd0);
        check("reset_cout", 32'(pipe.cout), 32'd0);
        check("reset_in_ready", 32'(pipe.in_ready), 32'd1);
`ifdef CLA_PIPE_OVF_EN
        check("reset_ovf", 32'(pipe.ovf), 32'd0);
`endif

        // Test 1: wrap-around and latency, counting the accepting edge as the first.
        @(posedge clk);
        #1;
        pipe.out_ready = 1'b1;
        pipe.A         = 24'hFFFFFF;
        pipe.B         = 24'h000001;
        pipe.cin       = 1'b0;
        pipe.sub       = 1'b0;
        pipe.in_valid  = 1'b1;
        exp_q.push_back(exp_word(1'b0, 1'b1, 24'h000000));
        edges = 0;
        @(posedge clk);
        edges++;
        #1 pipe.in_valid = 1'b0;
        while (!pipe.out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            #1;
        end
        check("t1_latency", edges, STAGES);
        drain("t1_drained");

        // Test 2: subtraction both ways plus carry boundaries.
        push(24'h000005, 24'h000007, 1'b0, 1'b1, exp_word(1'b0, 1'b0, 24'hFFFFFE));
        push(24'h000007, 24'h000005, 1'b0, 1'b1, exp_word(1'b0, 1'b1, 24'h000002));
        push(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, exp_word(1'b0, 1'b1, 24'hFFFFFF));
        push(24'h000000, 24'h000000, 1'b1, 1'b1, exp_word(1'b0, 1'b1, 24'h000000));
        push(24'h000FC0, 24'h000040, 1'b0, 1'b0, exp_word(1'b0, 1'b0, 24'h001000));
        pipe.in_valid = 1'b0;
        drain("t2_drained");

        // Test 3: fill with consumer stalled, then release with no gaps.
        pipe.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(24'(i), 24'(i), 1'b0, 1'b0, exp_word(1'b0, 1'b0, 24'(2 * i)));
        end
        pipe.A        = 24'd5;
        pipe.B        = 24'd5;
        pipe.in_valid = 1'b1;
        @(negedge clk);
        check("t3_full_in_ready", 32'(pipe.in_ready), 32'd0);
        check("t3_hold_S", 32'(pipe.S), 32'd2);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3_full_in_ready2", 32'(pipe.in_ready), 32'd0);
        check("t3_hold_valid", 32'(pipe.out_valid), 32'd1);
        check("t3_hold_S2", 32'(pipe.S), 32'd2);
        @(posedge clk);
        #1;
        pipe.out_ready = 1'b1;
        exp_q.push_back(exp_word(1'b0, 1'b0, 24'd10));
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("t3_no_gap", 32'(pipe.out_valid), 32'd1);
            @(posedge clk);
            #1;
            if (j == 0) pipe.in_valid = 1'b0;
        end
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // Test 4: 100 random back-to-back beats at full rate.
        t0 = cyc;
        for (int n = 0; n < 100; n++) begin
            ra = 24'($urandom);
            rb = 24'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            push(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        check("t4_throughput", cyc - t0, 100);
        pipe.in_valid = 1'b0;
        repeat (STAGES) @(negedge clk);
        #1;
        check("t4_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Test 5: reset with beats in flight drops them all.
        pipe.out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            ra = 24'($urandom);
            rb = 24'($urandom);
            push(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
        end
        pipe.in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_pre_reset_valid", 32'(pipe.out_valid), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        check("t5_out_valid", 32'(pipe.out_valid), 32'd0);
        check("t5_S", 32'(pipe.S), 32'd0);
        check("t5_cout", 32'(pipe.cout), 32'd0);
        check("t5_in_ready", 32'(pipe.in_ready), 32'd1);
`ifdef CLA_PIPE_OVF_EN
        check("t5_ovf", 32'(pipe.ovf), 32'd0);
`endif
        pipe.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t5_no_stale", 32'(pipe.out_valid), 32'd0);

        // Test 6: signed overflow cases (flag expected only when the feature is built).
        push(24'h7FFFFF, 24'h000001, 1'b0, 1'b0, exp_word(1'b1, 1'b0, 24'h800000));
        push(24'h800000, 24'h000001, 1'b0, 1'b1, exp_word(1'b1, 1'b1, 24'h7FFFFF));
        push(24'h000001, 24'h000001, 1'b0, 1'b0, exp_word(1'b0, 1'b0, 24'h000002));
        pipe.in_valid = 1'b0;
        drain("t6_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
